// File: rtl/seq_priority_encoder_pkg.sv
// Shared types for the sequential priority encoder.
// Two-state FSM: IDLE waits for a load, EMIT drains the pending vector.
package enc_pkg;

   localparam int DATA_WIDTH_DEF = 3;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_EMIT = 1'b1;

   typedef enum logic {
      IDLE = ST_IDLE,
      EMIT = ST_EMIT
   } state_t;

endpackage

// File: rtl/seq_priority_encoder_if.sv
// Index output handshake: producer drives idx_out/idx_valid,
// consumer drives idx_ready.
interface seq_priority_encoder_if #(
   parameter int DATA_WIDTH = 3
);

   logic [DATA_WIDTH-1:0] idx_out;
   logic                  idx_valid;
   logic                  idx_ready;

   modport master (
      output idx_out,
      output idx_valid,
      input  idx_ready
   );

   modport slave (
      input  idx_out,
      input  idx_valid,
      output idx_ready
   );

endinterface

// File: rtl/seq_priority_encoder_lowest_set_encoder.sv
// Combinational N -> DATA_WIDTH encoder of the lowest set bit.
// found is low (and idx zero) when the vector is empty.
module lowest_set_encoder #(
   parameter int DATA_WIDTH = 3
) (
   input  logic [2**DATA_WIDTH-1:0] req,
   output logic [DATA_WIDTH-1:0]    idx,
   output logic                     found
);

   localparam int N = 2**DATA_WIDTH;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      // Scan downward so the lowest set bit wins.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = DATA_WIDTH'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_priority_encoder.sv
// Captures a request vector and emits the index of each set bit,
// lowest first, one per valid/ready transfer.
module seq_priority_encoder
   import enc_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    load,
   input  logic [2**DATA_WIDTH-1:0] req_in,
   output logic                    busy,
   output logic                    none,
   output logic [DATA_WIDTH:0]     count_out,
   seq_priority_encoder_if.master  idx
);

   localparam int N = 2**DATA_WIDTH;

   state_t         state_q, state_d;
   logic [N-1:0]   pend_q, pend_d;
   logic           none_q, none_d;
   logic [DATA_WIDTH-1:0] low_idx;
   logic           low_found;
   logic           valid;

   lowest_set_encoder #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_lse (
      .req   (pend_q),
      .idx   (low_idx),
      .found (low_found)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
         none_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         none_q  <= none_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      none_d  = 1'b0;
      valid   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (en && load) begin
               if (req_in != '0) begin
                  pend_d  = req_in;
                  state_d = EMIT;
               end else begin
                  none_d = 1'b1;
               end
            end
         end
         EMIT: begin
            valid = en && low_found;
            if (valid && idx.idx_ready) begin
               // Clearing the lowest set bit is exactly pend & (pend - 1).
               pend_d = pend_q & (pend_q - N'(1));
               if (pend_d == '0) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count_out = '0;
      for (int i = 0; i < N; i++) begin
         count_out = count_out + (DATA_WIDTH+1)'(pend_q[i]);
      end
   end

   assign idx.idx_valid = valid;
   assign idx.idx_out   = valid ? low_idx : '0;
   assign busy          = (state_q == EMIT);
   assign none          = none_q;

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Vector table plus scoreboard queue of expected indices,
// with hand sequences for empty load and async reset.
module tb_seq_priority_encoder;

   logic       clk;
   logic       rst;
   logic       en;
   logic       load;
   logic [7:0] req_in;
   logic       busy;
   logic       none;
   logic [3:0] count_out;

   int n_chk;
   int n_fail;

   logic [2:0] q[$];

   typedef struct {
      logic [7:0] req;
      logic [2:0] exp_first;
      logic [3:0] exp_k;
      int         hold_at;
      int         hold_len;
      bit         use_en;
      bit         junk;
   } vec_t;

   vec_t tbl[7];

   seq_priority_encoder_if #(.DATA_WIDTH(3)) bus ();

   seq_priority_encoder #(.DATA_WIDTH(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .load      (load),
      .req_in    (req_in),
      .busy      (busy),
      .none      (none),
      .count_out (count_out),
      .idx       (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_valid"}, bus.idx_valid, 0);
      chk({tag, "_idx"}, bus.idx_out, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_count"}, count_out, 0);
   endtask

   task automatic run_vec(input vec_t v);
      int step;
      int guard;
      @(negedge clk);
      en = 1; bus.idx_ready = 1; load = 1; req_in = v.req;
      #1;
      chk("load_busy", busy, 0);
      for (int i = 0; i < 8; i++) begin
         if (v.req[i]) q.push_back(i[2:0]);
      end
      @(negedge clk);
      load   = v.junk;
      req_in = v.junk ? 8'hFF : 8'h00;
      #1;
      chk("first_idx", bus.idx_out, v.exp_first);
      chk("first_count", count_out, v.exp_k);
      step  = 0;
      guard = 0;
      while (q.size() > 0 && guard < 40) begin
         guard++;
         if (step == v.hold_at && v.hold_len > 0) begin
            repeat (v.hold_len) begin
               if (v.use_en) en = 0;
               else bus.idx_ready = 0;
               #1;
               chk("hold_count", count_out, q.size());
               chk("hold_busy", busy, 1);
               if (v.use_en) begin
                  chk("frz_valid", bus.idx_valid, 0);
                  chk("frz_idx", bus.idx_out, 0);
               end else begin
                  chk("stall_valid", bus.idx_valid, 1);
                  chk("stall_idx", bus.idx_out, q[0]);
               end
               @(negedge clk);
            end
            en = 1; bus.idx_ready = 1;
            #1;
         end
         chk("emit_valid", bus.idx_valid, 1);
         chk("emit_idx", bus.idx_out, q[0]);
         chk("emit_count", count_out, q.size());
         chk("emit_busy", busy, 1);
         chk("emit_none", none, 0);
         void'(q.pop_front());
         step++;
         @(negedge clk);
         #1;
      end
      load = 0; req_in = 0;
      chk("drain_timeout", q.size(), 0);
      chk_zero_outputs("done");
      q.delete();
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      rst = 1; en = 0; load = 0; req_in = 0; bus.idx_ready = 0;

      tbl[0] = '{8'hA4, 3'd2, 4'd3, 0, 0, 1'b0, 1'b0};
      tbl[1] = '{8'hA4, 3'd2, 4'd3, 0, 3, 1'b0, 1'b0};
      tbl[2] = '{8'h81, 3'd0, 4'd2, 0, 0, 1'b0, 1'b1};
      tbl[3] = '{8'h80, 3'd7, 4'd1, 0, 0, 1'b0, 1'b0};
      tbl[4] = '{8'h0E, 3'd1, 4'd3, 1, 2, 1'b1, 1'b0};
      tbl[5] = '{8'hFF, 3'd0, 4'd8, 0, 0, 1'b0, 1'b0};
      tbl[6] = '{8'h01, 3'd0, 4'd1, 2, 2, 1'b0, 1'b0};

      #12;
      chk_zero_outputs("reset");
      chk("reset_none", none, 0);
      rst = 0;

      for (int t = 0; t < 7; t++) begin
         run_vec(tbl[t]);
      end

      // Empty load: one none pulse, nothing emitted.
      @(negedge clk);
      en = 1; load = 1; req_in = 8'h00; bus.idx_ready = 1;
      @(negedge clk);
      load = 0;
      #1;
      chk("zero_none", none, 1);
      chk_zero_outputs("zero");
      @(negedge clk);
      #1;
      chk("zero_none_end", none, 0);
      chk_zero_outputs("zero_end");

      // Async reset mid-emission.
      @(negedge clk);
      load = 1; req_in = 8'hF0;
      @(negedge clk);
      load = 0; req_in = 0;
      #1;
      chk("rst_pre_idx", bus.idx_out, 4);
      @(negedge clk);
      #1;
      chk("rst_pre_idx2", bus.idx_out, 5);
      #2 rst = 1;
      #1;
      chk_zero_outputs("async_rst");
      chk("async_rst_none", none, 0);
      #3 rst = 0;
      run_vec('{8'h02, 3'd1, 4'd1, 0, 0, 1'b0, 1'b0});

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
